aes_shares_in_loader: RTL and testbench

// - Word-serial front end of the masked AES top: collects 32-bit bus words carrying the key shares and plaintext shares.
// - Assembles them into full 128*d-bit share vectors.
// - Presents them to the AES top as one valid/ready transaction (key + plaintext together).
// - Optional key reuse: a new plaintext can be encrypted under the last loaded key without re-sending 4*d key words.

---
 rtl/aes_shares_in_loader_pkg.sv | 24 ++
 rtl/aes_shares_in_loader_if.sv | 29 ++
 rtl/aes_shares_in_loader_shares_word_deser.sv | 35 +++
 rtl/aes_shares_in_loader.sv | 173 +++++++++++++++++
 tb/tb_aes_shares_in_loader.sv | 217 +++++++++++++++++++++
 5 files changed

// File: rtl/aes_shares_in_loader_pkg.sv
// Shared constants, state encoding and sizing helpers for the masked AES share loader.
// Imported by the loader top, its word deserialiser and its bus interface.
package aes_shares_in_loader_pkg;

  localparam int unsigned W_BUS    = 32;
  localparam int unsigned D_SHARES = 2;
  localparam int unsigned BLK      = 128;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_KEY  = 2'd1,
    ST_PT   = 2'd2,
    ST_FULL = 2'd3
  } state_e;

  function automatic int unsigned words_per_vec(input int unsigned d, input int unsigned w);
    return (BLK * d) / w;
  endfunction

  function automatic int unsigned cnt_width(input int unsigned nw);
    return (nw > 32'd1) ? $clog2(nw) : 32'd1;
  endfunction

endpackage

// File: rtl/aes_shares_in_loader_if.sv
// Word-stream input and share-vector output handshakes of the share loader.
// The loader uses the slave view; the word source / AES top side uses the master view.
interface aes_shares_in_loader_if
  import aes_shares_in_loader_pkg::*;
#(
  parameter int unsigned d = D_SHARES,
  parameter int unsigned W = W_BUS
) ();

  logic                 in_valid;
  logic                 in_ready;
  logic [W-1:0]         in_data;
  logic                 in_reuse_key;
  logic                 out_valid;
  logic                 out_ready;
  logic [BLK*d-1:0]     out_shares_key;
  logic [BLK*d-1:0]     out_shares_plaintext;

  modport slave (
    input  in_valid, in_data, in_reuse_key, out_ready,
    output in_ready, out_valid, out_shares_key, out_shares_plaintext
  );

  modport master (
    output in_valid, in_data, in_reuse_key, out_ready,
    input  in_ready, out_valid, out_shares_key, out_shares_plaintext
  );

endinterface

// File: rtl/aes_shares_in_loader_shares_word_deser.sv
// 128*d-bit share vector built from W-bit words; one word slot written per enabled cycle.
// Asynchronous clear wipes all share material.
module aes_shares_in_loader_shares_word_deser
  import aes_shares_in_loader_pkg::*;
#(
  parameter int unsigned d = D_SHARES,
  parameter int unsigned W = W_BUS
) (
  input  logic                                        clk,
  input  logic                                        rst_n,
  input  logic                                        wr_en,
  input  logic [cnt_width(words_per_vec(d, W))-1:0]   wr_idx,
  input  logic [W-1:0]                                wr_data,
  output logic [BLK*d-1:0]                            vec
);

  localparam int unsigned NW = words_per_vec(d, W);
  localparam int unsigned CW = cnt_width(NW);

  logic [W-1:0] word_r [NW];

  for (genvar i = 0; i < NW; i++) begin : g_word
    // Word slot i: cleared on reset, loaded when its index is addressed.
    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        word_r[i] <= '0;
      end else if (wr_en && (wr_idx == CW'(i))) begin
        word_r[i] <= wr_data;
      end
    end

    assign vec[W*i +: W] = word_r[i];
  end

endmodule

// File: rtl/aes_shares_in_loader.sv
// Word-serial front end of the masked AES top: gathers key and plaintext share words
// into full share vectors and hands them over as one valid/ready transaction.
module aes_shares_in_loader
  import aes_shares_in_loader_pkg::*;
#(
  parameter int unsigned d = D_SHARES,
  parameter int unsigned W = W_BUS
) (
  input  logic                   clk,
  input  logic                   rst_n,
  aes_shares_in_loader_if.slave  bus,
  output logic                   key_loaded
);

  localparam int unsigned    NW   = words_per_vec(d, W);
  localparam int unsigned    CW   = cnt_width(NW);
  localparam logic [CW-1:0]  LAST = CW'(NW - 1);

  if ((BLK % W) != 0) begin : g_bad_width
    $error("aes_shares_in_loader: 128 must be a multiple of W");
  end

  state_e          state_r;
  state_e          state_next_s;
  logic [CW-1:0]   cnt_r;
  logic [CW-1:0]   cnt_next_s;
  logic            key_loaded_r;
  logic            key_loaded_next_s;
  logic            in_ready_r;
  logic            out_valid_r;
  logic            hs_s;
  logic            last_s;
  logic            reuse_s;
  logic            key_we_s;
  logic            pt_we_s;
  logic [BLK*d-1:0] key_vec_s;
  logic [BLK*d-1:0] pt_vec_s;

  assign hs_s    = bus.in_valid & in_ready_r;
  assign last_s  = (cnt_r == LAST);
  assign reuse_s = bus.in_reuse_key & key_loaded_r;

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r <= ST_IDLE;
    end else begin
      state_r <= state_next_s;
    end
  end

  // Next-state decode.
  always_comb begin
    state_next_s = state_r;
    case (state_r)
      ST_IDLE: begin
        if (hs_s) begin
          state_next_s = reuse_s ? ST_PT : ST_KEY;
        end else begin
          state_next_s = ST_IDLE;
        end
      end
      ST_KEY: begin
        if (hs_s && last_s) begin
          state_next_s = ST_PT;
        end else begin
          state_next_s = ST_KEY;
        end
      end
      ST_PT: begin
        if (hs_s && last_s) begin
          state_next_s = ST_FULL;
        end else begin
          state_next_s = ST_PT;
        end
      end
      ST_FULL: begin
        if (out_valid_r && bus.out_ready) begin
          state_next_s = ST_IDLE;
        end else begin
          state_next_s = ST_FULL;
        end
      end
      default: state_next_s = ST_IDLE;
    endcase
  end

  // Word routing, counter and key-held tracking for the accepted word.
  always_comb begin
    key_we_s          = 1'b0;
    pt_we_s           = 1'b0;
    cnt_next_s        = cnt_r;
    key_loaded_next_s = key_loaded_r;
    case (state_r)
      ST_IDLE: begin
        if (hs_s && reuse_s) begin
          pt_we_s    = 1'b1;
          cnt_next_s = CW'(1);
        end else if (hs_s) begin
          // A fresh key invalidates the held one until its last word lands.
          key_we_s          = 1'b1;
          cnt_next_s        = CW'(1);
          key_loaded_next_s = 1'b0;
        end else begin
          cnt_next_s = cnt_r;
        end
      end
      ST_KEY: begin
        if (hs_s) begin
          key_we_s          = 1'b1;
          cnt_next_s        = last_s ? CW'(0) : cnt_r + CW'(1);
          key_loaded_next_s = last_s;
        end else begin
          cnt_next_s = cnt_r;
        end
      end
      ST_PT: begin
        if (hs_s) begin
          pt_we_s    = 1'b1;
          cnt_next_s = last_s ? CW'(0) : cnt_r + CW'(1);
        end else begin
          cnt_next_s = cnt_r;
        end
      end
      ST_FULL: begin
        cnt_next_s = cnt_r;
      end
      default: begin
        cnt_next_s = CW'(0);
      end
    endcase
  end

  // Counter, key-held flag and registered handshake outputs.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_r        <= '0;
      key_loaded_r <= 1'b0;
      in_ready_r   <= 1'b0;
      out_valid_r  <= 1'b0;
    end else begin
      cnt_r        <= cnt_next_s;
      key_loaded_r <= key_loaded_next_s;
      in_ready_r   <= (state_next_s != ST_FULL);
      out_valid_r  <= (state_next_s == ST_FULL);
    end
  end

  aes_shares_in_loader_shares_word_deser #(.d(d), .W(W)) u_key_deser (
    .clk     (clk),
    .rst_n   (rst_n),
    .wr_en   (key_we_s),
    .wr_idx  (cnt_r),
    .wr_data (bus.in_data),
    .vec     (key_vec_s)
  );

  aes_shares_in_loader_shares_word_deser #(.d(d), .W(W)) u_pt_deser (
    .clk     (clk),
    .rst_n   (rst_n),
    .wr_en   (pt_we_s),
    .wr_idx  (cnt_r),
    .wr_data (bus.in_data),
    .vec     (pt_vec_s)
  );

  assign bus.in_ready             = in_ready_r;
  assign bus.out_valid            = out_valid_r;
  assign bus.out_shares_key       = key_vec_s;
  assign bus.out_shares_plaintext = pt_vec_s;
  assign key_loaded               = key_loaded_r;

endmodule

// File: tb/tb_aes_shares_in_loader.sv
// Self-checking bench for aes_shares_in_loader (d=2): directed loads, backpressure,
// key reuse, reset recovery and random bubbles checked against a share-vector scoreboard.
module tb_aes_shares_in_loader;
  import aes_shares_in_loader_pkg::*;

  localparam int unsigned D  = 2;
  localparam int unsigned WW = 32;
  localparam int unsigned NW = 8;
  localparam int unsigned VW = 256;

  typedef struct packed {
    logic [VW-1:0] key;
    logic [VW-1:0] pt;
  } exp_t;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic key_loaded;

  exp_t          sb_q[$];
  int            n_checks = 0;
  int            n_pass = 0;
  logic [VW-1:0] m_key = '0;
  logic [VW-1:0] m_pt = '0;
  bit            m_key_loaded = 1'b0;

  always #5 clk = ~clk;

  aes_shares_in_loader_if #(.d(D), .W(WW)) bus ();

  aes_shares_in_loader #(.d(D), .W(WW)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .bus        (bus.slave),
    .key_loaded (key_loaded)
  );

  task automatic send_word(input logic [31:0] w, input logic reuse, output bit ok);
    int n = 0;
    ok = 1'b0;
    bus.in_valid = 1'b1;
    bus.in_data = w;
    bus.in_reuse_key = reuse;
    while (!bus.in_ready && n < 50) begin
      @(negedge clk);
      n++;
    end
    if (bus.in_ready) begin
      @(posedge clk);
      ok = 1'b1;
    end
    @(negedge clk);
    bus.in_valid = 1'b0;
    bus.in_reuse_key = 1'b0;
  endtask

  task automatic do_reset(input string tag);
    rst_n = 1'b0;
    #1;
    n_checks++; if (bus.in_ready !== 1'b0) $display("FAIL %s in_ready: got %0b want 0", tag, bus.in_ready); else n_pass++;
    n_checks++; if (bus.out_valid !== 1'b0) $display("FAIL %s out_valid: got %0b want 0", tag, bus.out_valid); else n_pass++;
    n_checks++; if (key_loaded !== 1'b0) $display("FAIL %s key_loaded: got %0b want 0", tag, key_loaded); else n_pass++;
    n_checks++; if (bus.out_shares_key !== '0) $display("FAIL %s key_zero: got %h want 0", tag, bus.out_shares_key); else n_pass++;
    n_checks++; if (bus.out_shares_plaintext !== '0) $display("FAIL %s pt_zero: got %h want 0", tag, bus.out_shares_plaintext); else n_pass++;
    m_key = '0;
    m_pt = '0;
    m_key_loaded = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    n_checks++; if (bus.in_ready !== 1'b1) $display("FAIL %s ready_after: got %0b want 1", tag, bus.in_ready); else n_pass++;
  endtask

  // Sends one transaction (key phase skipped when reuse applies) and queues its expected vectors.
  task automatic load_txn(input string tag, input bit reuse, input bit rnd, input logic [31:0] base, input bit bubbles);
    logic [VW-1:0] k;
    logic [VW-1:0] p;
    logic [31:0]   w;
    bit            use_key;
    bit            ok;
    int            nwords;
    int            j;
    use_key = reuse && m_key_loaded;
    k = m_key;
    p = m_pt;
    nwords = use_key ? NW : 2 * NW;
    for (int i = 0; i < nwords; i++) begin
      w = rnd ? $urandom : base + 32'(i);
      if (bubbles) begin
        for (int b = 0; b < 4 && $urandom_range(0, 1) == 1; b++) @(negedge clk);
      end
      if (!use_key && i < NW) begin
        k[WW*i +: WW] = w;
      end else begin
        j = use_key ? i : i - NW;
        p[WW*j +: WW] = w;
      end
      send_word(w, (i == 0) ? reuse : 1'($urandom_range(0, 1)), ok);
      n_checks++; if (!ok) $display("FAIL %s handshake_timeout: word %0d not accepted", tag, i); else n_pass++;
      if (i == nwords - 2) begin
        n_checks++; if (bus.out_valid !== 1'b0) $display("FAIL %s early_valid: got %0b want 0", tag, bus.out_valid); else n_pass++;
      end
    end
    n_checks++; if (bus.out_valid !== 1'b1) $display("FAIL %s valid_latency: got %0b want 1", tag, bus.out_valid); else n_pass++;
    m_key = k;
    m_pt = p;
    m_key_loaded = 1'b1;
    sb_q.push_back('{key: k, pt: p});
  endtask

  // Waits for out_valid, compares against the scoreboard head, then completes the handshake.
  task automatic collect(input string tag);
    exp_t e;
    int   n = 0;
    while (!bus.out_valid && n < 20) begin
      @(negedge clk);
      n++;
    end
    n_checks++; if (bus.out_valid !== 1'b1) $display("FAIL %s out_valid_timeout: got %0b want 1", tag, bus.out_valid); else n_pass++;
    n_checks++;
    if (sb_q.size() == 0) begin
      $display("FAIL %s scoreboard_empty: got 0 entries want 1", tag);
    end else begin
      n_pass++;
      e = sb_q.pop_front();
      n_checks++; if (bus.out_shares_key !== e.key) $display("FAIL %s key: got %h want %h", tag, bus.out_shares_key, e.key); else n_pass++;
      n_checks++; if (bus.out_shares_plaintext !== e.pt) $display("FAIL %s pt: got %h want %h", tag, bus.out_shares_plaintext, e.pt); else n_pass++;
    end
    n_checks++; if (key_loaded !== 1'b1) $display("FAIL %s key_loaded: got %0b want 1", tag, key_loaded); else n_pass++;
    bus.out_ready = 1'b1;
    @(negedge clk);
    bus.out_ready = 1'b0;
    n_checks++; if (bus.out_valid !== 1'b0) $display("FAIL %s release_valid: got %0b want 0", tag, bus.out_valid); else n_pass++;
    n_checks++; if (bus.in_ready !== 1'b1) $display("FAIL %s release_ready: got %0b want 1", tag, bus.in_ready); else n_pass++;
  endtask

  task automatic test_reset();
    @(negedge clk);
    do_reset("reset");
  endtask

  task automatic test_full_load();
    load_txn("full_load", 1'b0, 1'b0, 32'h0000_0001, 1'b0);
    n_checks++; if (bus.out_shares_key[31:0] !== 32'd1) $display("FAIL full_load key_w0: got %h want 1", bus.out_shares_key[31:0]); else n_pass++;
    n_checks++; if (bus.out_shares_key[255:224] !== 32'd8) $display("FAIL full_load key_w7: got %h want 8", bus.out_shares_key[255:224]); else n_pass++;
    n_checks++; if (bus.out_shares_plaintext[31:0] !== 32'd9) $display("FAIL full_load pt_w0: got %h want 9", bus.out_shares_plaintext[31:0]); else n_pass++;
    n_checks++; if (bus.out_shares_plaintext[255:224] !== 32'h10) $display("FAIL full_load pt_w7: got %h want 10", bus.out_shares_plaintext[255:224]); else n_pass++;
    n_checks++; if (key_loaded !== 1'b1) $display("FAIL full_load key_loaded: got %0b want 1", key_loaded); else n_pass++;
  endtask

  task automatic test_backpressure();
    for (int c = 0; c < 5; c++) begin
      bus.in_valid = 1'b1;
      bus.in_data = 32'hDEAD_0000 + 32'(c);
      n_checks++; if (bus.in_ready !== 1'b0) $display("FAIL backpressure in_ready: got %0b want 0", bus.in_ready); else n_pass++;
      n_checks++; if (bus.out_valid !== 1'b1) $display("FAIL backpressure out_valid: got %0b want 1", bus.out_valid); else n_pass++;
      n_checks++; if (bus.out_shares_key !== sb_q[0].key) $display("FAIL backpressure key_stable: got %h want %h", bus.out_shares_key, sb_q[0].key); else n_pass++;
      n_checks++; if (bus.out_shares_plaintext !== sb_q[0].pt) $display("FAIL backpressure pt_stable: got %h want %h", bus.out_shares_plaintext, sb_q[0].pt); else n_pass++;
      @(negedge clk);
    end
    collect("backpressure");
    bus.in_valid = 1'b0;
  endtask

  task automatic test_key_reuse();
    load_txn("key_reuse", 1'b1, 1'b0, 32'h0000_0100, 1'b0);
    collect("key_reuse");
  endtask

  task automatic test_reuse_no_key();
    do_reset("reuse_no_key_rst");
    load_txn("reuse_no_key", 1'b1, 1'b0, 32'h0000_00A0, 1'b0);
    n_checks++; if (bus.out_shares_key[31:0] !== 32'hA0) $display("FAIL reuse_no_key key_w0: got %h want a0", bus.out_shares_key[31:0]); else n_pass++;
    collect("reuse_no_key");
  endtask

  task automatic test_reset_mid_load();
    bit ok;
    for (int i = 0; i < 5; i++) begin
      send_word(32'h0000_0300 + 32'(i), 1'b0, ok);
      n_checks++; if (!ok) $display("FAIL mid_load handshake_timeout: word %0d not accepted", i); else n_pass++;
    end
    do_reset("mid_load_rst");
    load_txn("mid_load_after", 1'b1, 1'b0, 32'h0000_0200, 1'b0);
    collect("mid_load_after");
  endtask

  task automatic test_random();
    for (int t = 0; t < 100; t++) begin
      load_txn("random", 1'($urandom_range(0, 1)), 1'b1, 32'h0, 1'b1);
      collect("random");
    end
  endtask

  initial begin
    bus.in_valid = 1'b0;
    bus.in_data = '0;
    bus.in_reuse_key = 1'b0;
    bus.out_ready = 1'b0;
    test_reset();
    test_full_load();
    test_backpressure();
    test_key_reuse();
    test_reuse_no_key();
    test_reset_mid_load();
    test_random();
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached, %0d/%0d checks passed", n_pass, n_checks);
    $fatal(1);
  end

endmodule
